mux_scan: RTL

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_scan.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mux_scan.sv
// Registered channel multiplexer with single-shot manual select and auto-scan
// over all channels, with a valid/ready output handshake and an optional dwell gap.
module mux_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned DWELL_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      start,
  input  logic                      stop,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      wrap,
  output logic                      sel_err,
  output logic                      busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  localparam logic [SEL_W:0]   CH_COUNT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

  logic [1:0]         state, state_d;
  logic [WIDTH-1:0]   y_d;
  logic               y_valid_d;
  logic [SEL_W-1:0]   cur_ch_d;
  logic               wrap_d;
  logic               sel_err_d;
  logic               busy_d;
  logic               scan, scan_d;
  logic               stop_q, stop_d;
  logic [DWELL_W-1:0] dwell_lat, dwell_lat_d;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_d;

  logic               take_next;
  logic               stop_eff;
  logic               sel_oor;
  logic [SEL_W-1:0]   next_ch;

  // Channel selector; indices without a channel read as zero.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0] idx);
    pick = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) pick = bus[k*WIDTH +: WIDTH];
    end
  endfunction

  assign sel_oor  = ({1'b0, sel} >= CH_COUNT);
  assign next_ch  = (cur_ch == LAST_CH) ? '0 : cur_ch + SEL_W'(1);
  assign stop_eff = stop_q | stop;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    y_d         = y;
    y_valid_d   = y_valid;
    cur_ch_d    = cur_ch;
    wrap_d      = 1'b0;
    sel_err_d   = 1'b0;
    scan_d      = scan;
    stop_d      = stop_q;
    dwell_lat_d = dwell_lat;
    dwell_cnt_d = dwell_cnt;
    take_next   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          y_valid_d = 1'b1;
          state_d   = S_HOLD;
          if (mode) begin
            y_d         = pick(d, '0);
            cur_ch_d    = '0;
            scan_d      = 1'b1;
            dwell_lat_d = dwell;
          end else begin
            y_d       = sel_oor ? '0 : pick(d, sel);
            cur_ch_d  = sel;
            scan_d    = 1'b0;
            sel_err_d = sel_oor;
          end
        end
      end
      S_HOLD: begin
        if (scan && stop) stop_d = 1'b1;
        if (y_valid && y_ready) begin
          if (!scan || stop_eff) begin
            state_d   = S_IDLE;
            y_valid_d = 1'b0;
          end else if (dwell_lat == '0) begin
            take_next = 1'b1;
          end else begin
            state_d     = S_DWELL;
            y_valid_d   = 1'b0;
            dwell_cnt_d = dwell_lat;
          end
        end
      end
      S_DWELL: begin
        if (stop_eff) begin
          state_d = S_IDLE;
        end else if (dwell_cnt <= DWELL_W'(1)) begin
          take_next = 1'b1;
        end else begin
          dwell_cnt_d = dwell_cnt - DWELL_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        y_valid_d = 1'b0;
      end
    endcase

    // Scan advance shares one capture path for back-to-back and post-dwell cases
    if (take_next) begin
      y_d       = pick(d, next_ch);
      cur_ch_d  = next_ch;
      y_valid_d = 1'b1;
      state_d   = S_HOLD;
      wrap_d    = (cur_ch == LAST_CH);
    end

    if (state_d == S_IDLE) stop_d = 1'b0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      y         <= '0;
      y_valid   <= 1'b0;
      cur_ch    <= '0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
      busy      <= 1'b0;
      scan      <= 1'b0;
      stop_q    <= 1'b0;
      dwell_lat <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_d;
      y         <= y_d;
      y_valid   <= y_valid_d;
      cur_ch    <= cur_ch_d;
      wrap      <= wrap_d;
      sel_err   <= sel_err_d;
      busy      <= busy_d;
      scan      <= scan_d;
      stop_q    <= stop_d;
      dwell_lat <= dwell_lat_d;
      dwell_cnt <= dwell_cnt_d;
    end
  end

endmodule
